// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel divider, h/v counters, registered syncs, DE, coordinates and frame/line pulses.
// Optional line interrupt enabled by defining VTG_LINE_IRQ_EN; otherwise o_line_irq is tied low.
module video_timing_gen #(
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 11,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 31,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int PIX_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [11:0] i_irq_line,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_pix_ce,
  output logic        o_frame,
  output logic        o_line_irq,
  output logic [11:0] o_h,
  output logic [11:0] o_v,
  output logic [15:0] o_frame_cnt
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int H_TOTAL = H_BLANK + H_RES;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int V_TOTAL = V_BLANK + V_RES;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_S = 12'(H_FP);
  localparam logic [11:0] H_SYNC_E = 12'(H_FP + H_SYNC);
  localparam logic [11:0] H_ACT_S  = 12'(H_BLANK);
  localparam logic [11:0] V_SYNC_S = 12'(V_FP);
  localparam logic [11:0] V_SYNC_E = 12'(V_FP + V_SYNC);
  localparam logic [11:0] V_ACT_S  = 12'(V_BLANK);
  localparam logic        HS_ON    = 1'(H_POL);
  localparam logic        VS_ON    = 1'(V_POL);

  logic [DIV_W-1:0] div;
  logic [11:0]      h, v, h_nxt, v_nxt;
  logic [11:0]      oh_nxt, ov_nxt;
  logic             tick, h_wrap, v_wrap;
  logic             hs_nxt, vs_nxt, de_nxt;
  logic             irq_hit;

  // Outputs are decoded from the post-tick counter values so they update with o_pix_ce.
  always_comb begin
    tick   = i_en && (div == DIV_MAX);
    h_wrap = (h == H_LAST);
    v_wrap = (v == V_LAST);
    h_nxt  = h_wrap ? 12'd0 : h + 12'd1;
    v_nxt  = v;
    if (h_wrap) begin
      v_nxt = v_wrap ? 12'd0 : v + 12'd1;
    end
    hs_nxt = ((h_nxt >= H_SYNC_S) && (h_nxt < H_SYNC_E)) ? HS_ON : ~HS_ON;
    vs_nxt = ((v_nxt >= V_SYNC_S) && (v_nxt < V_SYNC_E)) ? VS_ON : ~VS_ON;
    de_nxt = (h_nxt >= H_ACT_S) && (v_nxt >= V_ACT_S);
    oh_nxt = de_nxt ? h_nxt - H_ACT_S : 12'd0;
    ov_nxt = de_nxt ? v_nxt - V_ACT_S : 12'd0;
  end

`ifdef VTG_LINE_IRQ_EN
  logic [12:0] irq_target;
  assign irq_target = {1'b0, i_irq_line} + 13'(V_BLANK);
  // Fires when the tick lands on column 0 of the requested active line.
  assign irq_hit = ({1'b0, i_irq_line} < 13'(V_RES)) && h_wrap
                   && ({1'b0, v_nxt} == irq_target);
`else
  logic irq_line_unused;
  assign irq_line_unused = ^i_irq_line;
  assign irq_hit         = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      o_hs        <= ~HS_ON;
      o_vs        <= ~VS_ON;
      o_de        <= 1'b0;
      o_pix_ce    <= 1'b0;
      o_frame     <= 1'b0;
      o_line_irq  <= 1'b0;
      o_h         <= '0;
      o_v         <= '0;
      o_frame_cnt <= '0;
    end else begin
      o_pix_ce   <= tick;
      o_frame    <= 1'b0;
      o_line_irq <= 1'b0;
      if (i_en) begin
        div <= (div == DIV_MAX) ? '0 : div + DIV_W'(1);
      end
      if (tick) begin
        h          <= h_nxt;
        v          <= v_nxt;
        o_hs       <= hs_nxt;
        o_vs       <= vs_nxt;
        o_de       <= de_nxt;
        o_h        <= oh_nxt;
        o_v        <= ov_nxt;
        o_line_irq <= irq_hit;
        if (h_wrap && v_wrap) begin
          o_frame     <= 1'b1;
          o_frame_cnt <= o_frame_cnt + 16'd1;
        end
      end
    end
  end

endmodule
